// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - shared types and defaults for the RV32M restoring divider
package riscv_div_pkg;

    localparam int DIV_DATA_WIDTH = 32;

    // One-hot FSM encoding; any other pattern is treated as corrupt and recovers to IDLE.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        FIX  = 4'b0100,
        DONE = 4'b1000
    } div_state_e;

    // Operation encodings shared with the instruction decoder.
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step
    import riscv_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  quo_msb_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_bit_o
);

    // The shifted partial remainder can exceed DATA_WIDTH bits when the divisor is large.
    logic [DATA_WIDTH:0] shifted;

    assign shifted = {rem_i, quo_msb_i};
    assign q_bit_o = (shifted >= {1'b0, divisor_i});
    // When the trial succeeds the true difference is below the divisor, so it fits in DATA_WIDTH bits.
    assign rem_o   = q_bit_o ? (shifted[DATA_WIDTH-1:0] - divisor_i) : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/divider_restoring.sv
// rtl/divider_restoring.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit; DIV_EARLY_ZERO_EN skips iteration on divide-by-zero
module divider_restoring
    import riscv_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] R,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  bz_q, bz_d;

    logic [DATA_WIDTH-1:0] a_mag, b_mag, step_rem;
    logic                  step_bit;

    // -0x80000000 wraps to itself, which read unsigned is exactly the magnitude 2^31.
    assign a_mag = (signed_op && A[DATA_WIDTH-1]) ? -A : A;
    assign b_mag = (signed_op && B[DATA_WIDTH-1]) ? -B : B;

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_msb_i(quo_q[DATA_WIDTH-1]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        bz_d    = bz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = signed_op & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
                    rneg_d  = signed_op & A[DATA_WIDTH-1];
                    bz_d    = (B == '0);
                    cnt_d   = CNT_W'(DATA_WIDTH);
                    state_d = CALC;
`ifdef DIV_EARLY_ZERO_EN
                    if (B == '0) begin
                        q_d     = '1;
                        r_d     = A;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[DATA_WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the remainder path already reproduces A; only Q needs forcing.
                q_d     = bz_q ? '1 : (qneg_q ? -quo_q : quo_q);
                r_d     = rneg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            bz_q    <= bz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_divider_restoring.sv
// tb/tb_divider_restoring.sv - directed and random checks of divider_restoring
module tb_divider_restoring;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] A, B, Q, R;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divider_restoring dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_op(signed_op),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int exp_latency(input logic [31:0] b);
        int lat = 34;
`ifdef DIV_EARLY_ZERO_EN
        if (b == 32'd0) lat = 1;
`endif
        return lat;
    endfunction

    // mode 0: plain; 1: extra start pulse mid-operation; 2: start held during the done cycle
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input string name, input int mode);
        int lat      = 0;
        int busy_cnt = 0;
        int elat     = exp_latency(b);
        A = a; B = b; signed_op = s; start = 1'b1;
        step();
        start = 1'b0; A = ~a; B = ~b; signed_op = ~s;
        for (int c = 1; c <= 60; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
            start = (mode == 1 && c == 10);
            if (start) begin
                A = 32'd1; B = 32'd1;
            end
            step();
        end
        check({name, " latency"}, lat, elat);
        check({name, " busy cycles"}, busy_cnt, elat - 1);
        check({name, " Q"}, Q, eq);
        check({name, " R"}, R, er);
        if (mode == 2) begin
            start = 1'b1; A = 32'd9; B = 32'd3;
        end
        step();
        start = 1'b0;
        check({name, " done pulse width"}, done, 1'b0);
        if (mode == 2) check({name, " start in DONE ignored"}, busy, 1'b0);
    endtask

    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                             output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678};
        vecs[4]  = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE};
        vecs[10] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5};
        vecs[11] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
        vecs[12] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'hFFFF_FFFE};

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
        step();
        step();
        rst = 1'b0;
        check("reset Q", Q, 32'd0);
        check("reset R", R, 32'd0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].eq, vecs[i].er,
                   $sformatf("vec%0d", i), 0);
        end

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "start mid-op", 1);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "start in done", 2);

        // Abort an operation with reset partway through.
        A = 32'd100; B = 32'd7; signed_op = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 19; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst abort busy", busy, 1'b0);
        check("rst abort done", done, 1'b0);
        check("rst abort Q", Q, 32'd0);
        check("rst abort R", R, 32'd0);
        begin
            int done_cnt = 0;
            int busy_cnt = 0;
            for (int c = 0; c < 40; c++) begin
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                step();
            end
            check("rst abort no done", done_cnt, 0);
            check("rst abort stays idle", busy_cnt, 0);
        end

        rst = 1'b1; start = 1'b1; A = 32'd100; B = 32'd7;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst beats start", busy, 1'b0);
        step();
        check("rst beats start later", busy, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb, eq, er;
            logic        rs;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rs, eq, er);
            run_op(ra, rb, rs, eq, er, $sformatf("rand%0d", i), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
